addr_seq_ctrl: RTL and testbench

Micro-sequencer that drives the control side of the address register file (PC, AR, SP): it accepts one address-level command at a time over a valid/ready handshake and expands it into the per-cycle RegSel, FunSel, OutCSel and OutDSel codes plus memory strobes. It sits between the instruction control unit and the address register file / memory, and turns "fetch", "push", "pop" and "load" requests into correctly ordered register updates and memory accesses.

---
 rtl/addr_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_addr_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_seq_ctrl.sv
// addr_seq_ctrl: micro-sequencer for the address register file (PC, AR, SP).
// Accepts one command at a time over CmdValid/CmdReady and expands it into
// per-cycle RegSel/FunSel/OutCSel/OutDSel codes and memory strobes.
// All outputs are decoded from the registered state and latched command only.
// Optional feature: define ASEQ_STACK_CHECK_EN to enable the push/pop depth
// checker (StackErr); without it StackErr is tied low and PUSH/POP always run.
module addr_seq_ctrl #(
  parameter int STACK_DEPTH = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CmdValid,
  input  logic [2:0] Cmd,
  output logic       CmdReady,
  output logic [2:0] RegSel,
  output logic [2:0] FunSel,
  output logic [1:0] OutCSel,
  output logic [1:0] OutDSel,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRLoadLo,
  output logic       IRLoadHi,
  output logic       Done,
  output logic       StackErr
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EX1  = 2'b01;
  localparam logic [1:0] S_EX2  = 2'b10;

  localparam logic [2:0] C_NOP   = 3'b000;
  localparam logic [2:0] C_FETCH = 3'b001;
  localparam logic [2:0] C_PUSH  = 3'b010;
  localparam logic [2:0] C_POP   = 3'b011;
  localparam logic [2:0] C_LDPC  = 3'b100;
  localparam logic [2:0] C_LDAR  = 3'b101;
  localparam logic [2:0] C_LDSP  = 3'b110;

  localparam logic [2:0] F_DEC  = 3'b000;
  localparam logic [2:0] F_INC  = 3'b001;
  localparam logic [2:0] F_LOAD = 3'b010;

  // Active-low enables: bit2 PC, bit1 AR, bit0 SP
  localparam logic [2:0] EN_NONE = 3'b111;
  localparam logic [2:0] EN_PC   = 3'b011;
  localparam logic [2:0] EN_AR   = 3'b101;
  localparam logic [2:0] EN_SP   = 3'b110;

  localparam logic [1:0] SRC_PC = 2'b00;
  localparam logic [1:0] SRC_SP = 2'b11;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [2:0] r_cmd;
  logic       w_err;
  logic       w_two_cycle;
  logic [1:0] w_dsel;

`ifdef ASEQ_STACK_CHECK_EN
  logic [DEPTH_W-1:0] r_depth;

  // Rejected stack operation: detected in EX1 from the registered depth
  assign w_err = (r_state == S_EX1) &&
                 (((r_cmd == C_PUSH) && (r_depth == DEPTH_W'(STACK_DEPTH))) ||
                  ((r_cmd == C_POP)  && (r_depth == '0)));

  // Depth counter: commits on EX2 of PUSH/POP, LDSP re-bases SP so it clears
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_depth <= '0;
    end else if ((r_state == S_EX2) && (r_cmd == C_PUSH)) begin
      r_depth <= r_depth + DEPTH_W'(1);
    end else if ((r_state == S_EX2) && (r_cmd == C_POP)) begin
      r_depth <= r_depth - DEPTH_W'(1);
    end else if ((r_state == S_EX1) && (r_cmd == C_LDSP)) begin
      r_depth <= '0;
    end
  end
`else
  logic w_unused_depth_cfg;
  assign w_unused_depth_cfg = ^DEPTH_W'(STACK_DEPTH);
  assign w_err = 1'b0;
`endif

  assign w_two_cycle = (r_cmd == C_FETCH) || (r_cmd == C_PUSH) || (r_cmd == C_POP);

  // State register; reset drops any in-flight command
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Command latch: only loaded on accept, never observed outside EX1/EX2
  always_ff @(posedge Clock) begin
    if (!Reset && (r_state == S_IDLE) && CmdValid) begin
      r_cmd <= Cmd;
    end
  end

  // Next-state: single-cycle commands and rejected stack ops return from EX1
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:  w_next_state = CmdValid ? S_EX1 : S_IDLE;
      S_EX1:   w_next_state = (w_two_cycle && !w_err) ? S_EX2 : S_IDLE;
      S_EX2:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Moore output decode from state and latched command
  always_comb begin
    CmdReady = (r_state == S_IDLE);
    RegSel   = EN_NONE;
    FunSel   = F_DEC;
    w_dsel   = SRC_PC;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRLoadLo = 1'b0;
    IRLoadHi = 1'b0;
    Done     = 1'b0;
    StackErr = 1'b0;
    case (r_state)
      S_EX1: begin
        if (w_err) begin
          Done     = 1'b1;
          StackErr = 1'b1;
        end else begin
          case (r_cmd)
            C_FETCH: begin
              MemRead  = 1'b1;
              IRLoadLo = 1'b1;
              RegSel   = EN_PC;
              FunSel   = F_INC;
            end
            C_PUSH: begin
              RegSel = EN_SP;
              FunSel = F_DEC;
            end
            C_POP: begin
              w_dsel  = SRC_SP;
              MemRead = 1'b1;
            end
            C_LDPC: begin
              RegSel = EN_PC;
              FunSel = F_LOAD;
              Done   = 1'b1;
            end
            C_LDAR: begin
              RegSel = EN_AR;
              FunSel = F_LOAD;
              Done   = 1'b1;
            end
            C_LDSP: begin
              RegSel = EN_SP;
              FunSel = F_LOAD;
              Done   = 1'b1;
            end
            default: Done = 1'b1;
          endcase
        end
      end
      S_EX2: begin
        Done = 1'b1;
        case (r_cmd)
          C_FETCH: begin
            MemRead  = 1'b1;
            IRLoadHi = 1'b1;
            RegSel   = EN_PC;
            FunSel   = F_INC;
          end
          C_PUSH: begin
            w_dsel   = SRC_SP;
            MemWrite = 1'b1;
          end
          C_POP: begin
            RegSel = EN_SP;
            FunSel = F_INC;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign OutDSel = w_dsel;
  assign OutCSel = w_dsel;

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// tb_addr_seq_ctrl: directed and randomized checks of addr_seq_ctrl against a
// command-level model that expands each accepted command into a queue of
// expected per-cycle output records.
module tb_addr_seq_ctrl;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic       rdy;
    logic [2:0] rs;
    logic [2:0] fs;
    logic [1:0] oc;
    logic [1:0] od;
    logic       mr;
    logic       mw;
    logic       lo;
    logic       hi;
    logic       done;
    logic       err;
  } outs_t;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       CmdValid = 1'b0;
  logic [2:0] Cmd = 3'b000;
  logic       CmdReady, MemRead, MemWrite, IRLoadLo, IRLoadHi, Done, StackErr;
  logic [2:0] RegSel, FunSel;
  logic [1:0] OutCSel, OutDSel;

  outs_t obs, exp_o;
  outs_t q[$];
  int    m_depth = 0;
  int    checks = 0;
  int    errors = 0;
  int    done_cnt;

  addr_seq_ctrl #(.STACK_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .Cmd(Cmd),
    .CmdReady(CmdReady), .RegSel(RegSel), .FunSel(FunSel),
    .OutCSel(OutCSel), .OutDSel(OutDSel), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRLoadLo(IRLoadLo), .IRLoadHi(IRLoadHi),
    .Done(Done), .StackErr(StackErr)
  );

  always #5 Clock = ~Clock;

  assign obs = {CmdReady, RegSel, FunSel, OutCSel, OutDSel,
                MemRead, MemWrite, IRLoadLo, IRLoadHi, Done, StackErr};

  function automatic outs_t idle_o();
    outs_t o;
    o = '0;
    o.rdy = 1'b1;
    o.rs  = 3'b111;
    return o;
  endfunction

  function automatic outs_t busy_o();
    outs_t o;
    o = idle_o();
    o.rdy = 1'b0;
    return o;
  endfunction

  function automatic bit chk_en();
`ifdef ASEQ_STACK_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expand one accepted command into the cycles it should occupy
  task automatic enqueue(input logic [2:0] c);
    outs_t a, b;
    a = busy_o();
    b = busy_o();
    case (c)
      3'd1: begin
        a.mr = 1; a.lo = 1; a.rs = 3'b011; a.fs = 3'b001;
        b = a; b.lo = 0; b.hi = 1; b.done = 1;
        q.push_back(a); q.push_back(b);
      end
      3'd2: begin
        if (chk_en() && m_depth == DEPTH) begin
          a.done = 1; a.err = 1; q.push_back(a);
        end else begin
          a.rs = 3'b110; a.fs = 3'b000;
          b.od = 2'b11; b.oc = 2'b11; b.mw = 1; b.done = 1;
          q.push_back(a); q.push_back(b);
          m_depth++;
        end
      end
      3'd3: begin
        if (chk_en() && m_depth == 0) begin
          a.done = 1; a.err = 1; q.push_back(a);
        end else begin
          a.od = 2'b11; a.oc = 2'b11; a.mr = 1;
          b.rs = 3'b110; b.fs = 3'b001; b.done = 1;
          q.push_back(a); q.push_back(b);
          m_depth--;
        end
      end
      3'd4: begin a.rs = 3'b011; a.fs = 3'b010; a.done = 1; q.push_back(a); end
      3'd5: begin a.rs = 3'b101; a.fs = 3'b010; a.done = 1; q.push_back(a); end
      3'd6: begin a.rs = 3'b110; a.fs = 3'b010; a.done = 1; q.push_back(a); m_depth = 0; end
      default: begin a.done = 1; q.push_back(a); end
    endcase
  endtask

  // Drive one cycle of inputs, advance the model, land on the next negedge
  task automatic step(input logic rst, input logic v, input logic [2:0] c);
    Reset = rst; CmdValid = v; Cmd = c;
    @(posedge Clock);
    if (rst) begin
      q.delete();
      m_depth = 0;
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (v) begin
      enqueue(c);
    end
    @(negedge Clock);
    exp_o = (q.size() != 0) ? q[0] : idle_o();
  endtask

  task automatic test_reset();
    step(1, 1, 3'd1);
    step(1, 0, 3'd0);
    checks++;
    if (obs !== 17'h1E000) begin
      errors++; $display("FAIL reset_idle got=%h want=%h", obs, 17'h1E000);
    end
    step(0, 0, 3'd0);
  endtask

  task automatic test_fetch();
    step(0, 1, 3'd1);
    checks++;
    if (RegSel !== 3'b011 || FunSel !== 3'b001 || MemRead !== 1'b1 || IRLoadLo !== 1'b1 || Done !== 1'b0) begin
      errors++; $display("FAIL fetch_ex1 got=%h want=%h", obs, exp_o);
    end
    step(0, 0, 3'd0);
    checks++;
    if (IRLoadHi !== 1'b1 || Done !== 1'b1 || obs !== exp_o) begin
      errors++; $display("FAIL fetch_ex2 got=%h want=%h", obs, exp_o);
    end
    step(0, 0, 3'd0);
    checks++;
    if (CmdReady !== 1'b1 || obs !== exp_o) begin
      errors++; $display("FAIL fetch_ready got=%h want=%h", obs, exp_o);
    end
  endtask

  task automatic test_push_pop();
    logic [2:0] seq [4] = '{3'd2, 3'd0, 3'd3, 3'd0};
    for (int i = 0; i < 4; i++) begin
      step(0, seq[i] != 3'd0, seq[i]);
      checks++;
      if (obs !== exp_o) begin
        errors++; $display("FAIL push_pop[%0d] got=%h want=%h", i, obs, exp_o);
      end
    end
    step(0, 0, 3'd0);
    checks++;
    if (obs !== idle_o()) begin
      errors++; $display("FAIL push_pop_idle got=%h want=%h", obs, idle_o());
    end
  endtask

  task automatic test_back_to_back();
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 3'd5);
      if (Done === 1'b1) done_cnt++;
      checks++;
      if (obs !== exp_o) begin
        errors++; $display("FAIL ldar_b2b[%0d] got=%h want=%h", i, obs, exp_o);
      end
    end
    checks++;
    if (done_cnt != 3) begin
      errors++; $display("FAIL ldar_b2b_count got=%0d want=3", done_cnt);
    end
    step(0, 0, 3'd0);
  endtask

  task automatic test_reset_mid();
    step(0, 1, 3'd1);
    step(1, 1, 3'd1);
    checks++;
    if (obs !== idle_o() || obs !== exp_o) begin
      errors++; $display("FAIL reset_mid_fetch got=%h want=%h", obs, idle_o());
    end
    step(0, 0, 3'd0);
    checks++;
    if (Done !== 1'b0 || CmdReady !== 1'b1) begin
      errors++; $display("FAIL reset_mid_nodone got=%h want=%h", obs, idle_o());
    end
    step(0, 1, 3'd2);
    step(0, 0, 3'd0);
    step(1, 0, 3'd0);
    checks++;
    if (obs !== exp_o) begin
      errors++; $display("FAIL reset_mid_push got=%h want=%h", obs, exp_o);
    end
  endtask

  task automatic test_reserved();
    step(0, 1, 3'd7);
    checks++;
    if (Done !== 1'b1 || StackErr !== 1'b0 || obs !== exp_o) begin
      errors++; $display("FAIL reserved got=%h want=%h", obs, exp_o);
    end
    step(0, 0, 3'd0);
  endtask

  task automatic test_stack();
    logic [2:0] seq [4] = '{3'd3, 3'd2, 3'd2, 3'd2};
    step(1, 0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, seq[i]);
      checks++;
      if (obs !== exp_o) begin
        errors++; $display("FAIL stack_ex1[%0d] got=%h want=%h", i, obs, exp_o);
      end
      while (q.size() != 0) begin
        step(0, 0, 3'd0);
        checks++;
        if (obs !== exp_o) begin
          errors++; $display("FAIL stack_tail[%0d] got=%h want=%h", i, obs, exp_o);
        end
      end
    end
  endtask

  task automatic test_random();
    logic r, v;
    logic [2:0] c;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(99) < 3);
      v = ($urandom_range(99) < 65);
      c = 3'($urandom_range(7));
      step(r, v, c);
      checks++;
      if (obs !== exp_o) begin
        errors++; $display("FAIL random[%0d] got=%h want=%h", i, obs, exp_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_push_pop();
    test_back_to_back();
    test_reset_mid();
    test_reserved();
    test_stack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
